divider_sweep_ctrl: RTL and testbench

- Sequencer for the 8-bit presettable programmable divider (two cascaded 4-bit up/down counters with active-low parallel load and carry-out).
- Holds a small table of divisor load values and steps through them; each value is held for a programmable number of divider output periods.
- Drives the divider's load strobe and load value.
- Gives a frequency-sweep source for the lab clock-generation chain, without manual switch changes.

---
 rtl/divider_sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_divider_sweep_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_sweep_ctrl.sv
// Sweep sequencer for the 8-bit presettable programmable divider: steps a small
// table of load values, holding each one for a programmable number of divider periods.
module divider_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_loop,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [7:0]       i_hold_periods,
    input  logic             i_co,
    output logic             o_load_n,
    output logic [WIDTH-1:0] o_load_value,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW-1:0]    o_idx,
    output logic             o_period_tick
);

    // state | meaning
    // IDLE  | waiting for start; table writable
    // LOAD  | one-cycle parallel load of table[idx]
    // RUN   | counting divider periods via co
    // NEXT  | advance / wrap the table index
    // DONE  | one-cycle done pulse after a single pass
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_table [DEPTH];
    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;
    logic [7:0]       r_hold;
    logic [7:0]       w_hold_nxt;
    logic             r_loop;
    logic             w_loop_nxt;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_nxt;
    logic             r_load_n;
    logic             w_load_n_nxt;
    logic [WIDTH-1:0] r_load_value;
    logic [WIDTH-1:0] w_load_value_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_tick;
    logic             w_tick_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= 8'd0;
            r_hold       <= 8'd0;
            r_loop       <= 1'b0;
            r_idx        <= '0;
            r_load_n     <= 1'b1;
            r_load_value <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_hold       <= w_hold_nxt;
            r_loop       <= w_loop_nxt;
            r_idx        <= w_idx_nxt;
            r_load_n     <= w_load_n_nxt;
            r_load_value <= w_load_value_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_tick       <= w_tick_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wr_en && (r_state == S_IDLE)) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_hold_nxt       = r_hold;
        w_loop_nxt       = r_loop;
        w_idx_nxt        = r_idx;
        w_load_n_nxt     = 1'b1;
        w_load_value_nxt = r_load_value;
        w_tick_nxt       = 1'b0;

        // stop overrides everything outside IDLE; co in the same cycle is dropped
        if ((r_state != S_IDLE) && i_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        w_hold_nxt  = (i_hold_periods == 8'd0) ? 8'd1 : i_hold_periods;
                        w_loop_nxt  = i_loop;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_count_nxt = 8'd0;
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (i_co) begin
                        w_tick_nxt = 1'b1;
                        if (r_count == (r_hold - 8'd1)) begin
                            w_state_nxt = S_NEXT;
                        end else begin
                            w_count_nxt  = r_count + 8'd1;
                            w_load_n_nxt = 1'b0;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = S_LOAD;
                    end else if (r_loop) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // outputs are registered from the state being entered
        if (w_state_nxt == S_LOAD) begin
            w_load_n_nxt     = 1'b0;
            w_load_value_nxt = r_table[w_idx_nxt];
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    assign o_load_n      = r_load_n;
    assign o_load_value  = r_load_value;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_idx         = r_idx;
    assign o_period_tick = r_tick;

endmodule

// File: tb/tb_divider_sweep_ctrl.sv
// Bench for divider_sweep_ctrl: directed sweeps with random table contents, hold
// counts and co spacing, checked against a table-level model of the expected load sequence.
module tb_divider_sweep_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             start   = 1'b0;
    logic             stop    = 1'b0;
    logic             loop_i  = 1'b0;
    logic             wr_en   = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [7:0]       hold    = 8'd0;
    logic             co      = 1'b0;
    logic             load_n;
    logic [WIDTH-1:0] load_value;
    logic             busy;
    logic             done;
    logic [AW-1:0]    idx;
    logic             period_tick;

    divider_sweep_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_stop         (stop),
        .i_loop         (loop_i),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_hold_periods (hold),
        .i_co           (co),
        .o_load_n       (load_n),
        .o_load_value   (load_value),
        .o_busy         (busy),
        .o_done         (done),
        .o_idx          (idx),
        .o_period_tick  (period_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected table contents: only writes issued while idle are applied
    logic [WIDTH-1:0] tbl_m [DEPTH];

    // observed load strobes, ticks and done pulses
    logic [WIDTH-1:0] mon_val [$];
    logic [AW-1:0]    mon_idx [$];
    int               mon_ticks = 0;
    int               mon_dones = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_n === 1'b0) begin
                mon_val.push_back(load_value);
                mon_idx.push_back(idx);
            end
            if (period_tick === 1'b1) mon_ticks++;
            if (done === 1'b1) mon_dones++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_tbl(input int a, input logic [WIDTH-1:0] d, input bit apply);
        wr_addr = AW'(a);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        if (apply) tbl_m[a] = d;
    endtask

    task automatic pulse_start(input logic [7:0] h, input bit lp);
        hold   = h;
        loop_i = lp;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("start_load_n", load_n, 0);
        check("start_idx", idx, 0);
        check("start_value", load_value, tbl_m[0]);
        check("start_busy", busy, 1);
    endtask

    // each co is issued only after a load strobe has been seen, so it always lands in RUN
    task automatic run_co(input int n_co, input int h_eff, input bit lp);
        for (int c = 0; c < n_co; c++) begin
            int  t;
            bit  entry_end;
            bit  pass_end;
            t = 0;
            while (load_n !== 1'b0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("load_wait", load_n, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            co = 1'b1;
            @(negedge clk);
            co = 1'b0;
            entry_end = ((c + 1) % h_eff) == 0;
            pass_end  = !lp && ((c + 1) == h_eff * DEPTH);
            check("tick_after_co", period_tick, 1);
            if (entry_end) begin
                check("entry_end_load_n", load_n, 1);
                if (!pass_end) begin
                    @(negedge clk);
                    check("next_load_latency", load_n, 0);
                end
            end else begin
                check("reload_load_n", load_n, 0);
            end
        end
    endtask

    task automatic check_loads(input int base, input int n, input int h_eff);
        check("load_count", mon_val.size() - base, n);
        for (int k = 0; k < n && (base + k) < mon_val.size(); k++) begin
            int e;
            e = (k / h_eff) % DEPTH;
            check("load_value_seq", mon_val[base + k], tbl_m[e]);
            check("load_idx_seq", mon_idx[base + k], e);
        end
    endtask

    task automatic one_pass(input logic [7:0] h);
        int b, tk, dn, he;
        he = (h == 8'd0) ? 1 : int'(h);
        b  = mon_val.size();
        tk = mon_ticks;
        dn = mon_dones;
        pulse_start(h, 1'b0);
        run_co(he * DEPTH, he, 1'b0);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_idx", idx, DEPTH - 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_idx", idx, DEPTH - 1);
        repeat (2) @(negedge clk);
        check_loads(b, he * DEPTH, he);
        check("tick_count", mon_ticks - tk, he * DEPTH);
        check("done_count", mon_dones - dn, 1);
    endtask

    initial begin
        int b, tk, dn;
        for (int i = 0; i < DEPTH; i++) tbl_m[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_load_n", load_n, 1);
        check("rst_value", load_value, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", idx, 0);
        check("rst_tick", period_tick, 0);
        rst_n = 1'b1;
        @(negedge clk);

        write_tbl(0, 8'h99, 1'b1);
        write_tbl(1, 8'h40, 1'b1);
        write_tbl(2, 8'h10, 1'b1);
        write_tbl(3, 8'h05, 1'b1);
        one_pass(8'd3);

        // wrap forever with hold=1
        b  = mon_val.size();
        dn = mon_dones;
        pulse_start(8'd1, 1'b1);
        run_co(8, 1, 1'b1);
        check("wrap_idx", idx, 0);
        check("wrap_value", load_value, 8'h99);
        repeat (3) @(negedge clk);
        check("wrap_busy", busy, 1);
        check("wrap_no_done", mon_dones - dn, 0);
        check_loads(b, 9, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("wrap_stop_busy", busy, 0);

        // hold of 0 acts like 1
        one_pass(8'd0);

        // stop at idx=1, with a write attempted while busy
        dn = mon_dones;
        pulse_start(8'd2, 1'b0);
        run_co(2, 2, 1'b0);
        check("pre_stop_idx", idx, 1);
        write_tbl(1, 8'h22, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_idx", idx, 1);
        check("stop_load_n", load_n, 1);
        check("stop_done", done, 0);
        co = 1'b1;
        @(negedge clk);
        co = 1'b0;
        check("stop_co_tick", period_tick, 0);
        @(negedge clk);
        check("stop_co_tick2", period_tick, 0);
        check("stop_no_done", mon_dones - dn, 0);

        one_pass(8'd1);
        write_tbl(1, 8'h22, 1'b1);
        one_pass(8'd1);

        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < DEPTH; a++) write_tbl(a, WIDTH'($urandom), 1'b1);
            one_pass(8'($urandom_range(0, 4)));
        end

        // asynchronous reset during RUN at idx=2
        tk = mon_ticks;
        pulse_start(8'd1, 1'b0);
        run_co(2, 1, 1'b0);
        @(negedge clk);
        check("pre_rst_idx", idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_load_n", load_n, 1);
        check("arst_busy", busy, 0);
        check("arst_idx", idx, 0);
        check("arst_done", done, 0);
        check("arst_value", load_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tbl_m[i] = '0;
        @(negedge clk);
        one_pass(8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
